alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder, plus two operands, and produces a registered result with a zero flag. Sits directly downstream of the ALU decoder, between operand fetch and writeback. Adds a valid/ready handshake on both sides. Shifts use an iterative 1-bit-per-cycle shifter unless the barrel option is compiled in.

---
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result.
// Shifts iterate one bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   cnt_r;
    logic [3:0]       op_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             accept_s;
    logic             start_shift_s;

    // Single-cycle result; in the iterative build a shift only reaches here with shamt 0.
    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0] ctrl,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [SHW-1:0]   shamt;
        shamt = b[SHW-1:0];
        case (ctrl)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a >> shamt;
            OP_SRA:  r = $signed(a) >>> shamt;
`else
            OP_SLL:  r = a;
            OP_SRL:  r = a;
            OP_SRA:  r = a;
`endif
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] ctrl,
                                                    input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        case (ctrl)
            OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s = in_valid && in_ready;

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift_s = 1'b0;
`else
    logic is_shift_s;
    assign is_shift_s    = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign start_shift_s = is_shift_s && (src_b[SHW-1:0] != {SHW{1'b0}});
`endif

    // Control FSM with the result, shift datapath and output flags registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            result_r    <= {WIDTH{1'b0}};
            work_r      <= {WIDTH{1'b0}};
            cnt_r       <= {SHW{1'b0}};
            op_r        <= 4'b0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // An accept in DONE hands off the held result on this same edge.
                    if (accept_s) begin
                        op_r <= alu_ctrl;
                        if (start_shift_s) begin
                            state_r     <= ST_SHIFT;
                            work_r      <= src_a;
                            cnt_r       <= src_b[SHW-1:0];
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r     <= ST_DONE;
                            result_r    <= alu_compute(alu_ctrl, src_a, src_b);
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_SHIFT: begin
                    work_r <= shift_step(op_r, work_r);
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r     <= ST_DONE;
                        result_r    <= shift_step(op_r, work_r);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign zero      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rnd_rdy = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        int          lat;
    } exp_t;
    exp_t q[$];
    logic mon_ev;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    // Reference: what each opcode means arithmetically.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << sh;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a ^ b;
            4'd7: return a >> sh;
            4'd8: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Extra edges after the accept edge before the result shows.
    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 0;
`else
        if ((c == 4'd4 || c == 4'd7 || c == 4'd8) && b[4:0] != 5'd0) return int'(b[4:0]);
        return 0;
`endif
    endfunction

    // Compare process: checks every observable output on every falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            mon_ev = (q.size() > 0) && (cyc >= q[0].due);
            chk("out_valid", out_valid, mon_ev);
            if (q.size() > 0 && !mon_ev) chk("busy", busy, q[0].lat > 0);
            else chk("busy", busy, 1'b0);
            chk("in_ready", in_ready, (q.size() == 0) || (mon_ev && out_ready));
            if (mon_ev) begin
                chk("result", result, q[0].res);
                chk("zero", zero, q[0].res == 32'd0);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back('{res: model(alu_ctrl, src_a, src_b),
                              due: cyc + 1 + model_lat(alu_ctrl, src_b),
                              lat: model_lat(alu_ctrl, src_b)});
        end
    end

    task automatic step_inputs();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int waits);
        in_valid = 1'b1;
        alu_ctrl = c;
        src_a    = a;
        src_b    = b;
        waits    = 0;
        forever begin
            @(negedge clk);
            waits++;
            if (in_ready) break;
            if (waits > 200) begin
                timeout_fail("accept");
                break;
            end
            step_inputs();
        end
        step_inputs();
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic expect_result(input logic [31:0] exp, input string nm, output int n, output int bz);
        n  = 0;
        bz = 0;
        forever begin
            @(negedge clk);
            n++;
            if (busy) bz++;
            if (out_valid) break;
            if (n > 100) begin
                timeout_fail(nm);
                break;
            end
        end
        chk(nm, result, exp);
        chk({nm, "_zero"}, zero, exp == 32'd0);
        @(posedge clk);
        #1;
    endtask

    int w, n, bz, guard;
    int shift_lat4, shift_lat31;
    logic [3:0]  rc;
    logic [31:0] ra, rb;

    initial begin
`ifdef ALU_BARREL_SHIFT_EN
        shift_lat4 = 0; shift_lat31 = 0;
`else
        shift_lat4 = 4; shift_lat31 = 31;
`endif
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step_inputs();

        do_op(4'd0, 32'hFFFF_FFFF, 32'd1, w); expect_result(32'd0, "add_wrap", n, bz);
        chk("add_lat", n, 1);
        do_op(4'd1, 32'd5, 32'd7, w);         expect_result(32'hFFFF_FFFE, "sub_neg", n, bz);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd1, w); expect_result(32'd1, "slt_signed", n, bz);
        do_op(4'hF, 32'h1234_5678, 32'h9, w); expect_result(32'd0, "code_f", n, bz);

        do_op(4'd8, 32'h8000_0000, 32'd4, w); expect_result(32'hF800_0000, "sra4", n, bz);
        chk("sra4_lat", n - 1, shift_lat4);
        chk("sra4_busy", bz, shift_lat4);
        do_op(4'd7, 32'h8000_0000, 32'd4, w); expect_result(32'h0800_0000, "srl4", n, bz);
        do_op(4'd4, 32'h1234_5678, 32'h20, w); expect_result(32'h1234_5678, "sll0", n, bz);
        chk("sll0_lat", n, 1);
        do_op(4'd4, 32'd1, 32'd31, w);        expect_result(32'h8000_0000, "sll31", n, bz);
        chk("sll31_lat", n - 1, shift_lat31);
        chk("sll31_busy", bz, shift_lat31);

        // Backpressure then simultaneous handoff.
        out_ready = 1'b0;
        do_op(4'd0, 32'd10, 32'd20, w); expect_result(32'd30, "bp_add", n, bz);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_hold", result, 32'd30);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_op(4'd6, 32'hF0, 32'hFF, w);
        chk("handoff_waits", w, 1);
        expect_result(32'h0F, "handoff_xor", n, bz);
        chk("handoff_lat", n, 1);

        // Streaming: each op must be accepted on its first cycle.
        for (int i = 0; i < 8; i++) begin
            do_op(4'd0, 32'(i * 100), 32'(i), w);
            if (i > 0) chk("stream_accept", w, 1);
        end
        repeat (3) step_inputs();

        // Reset in the middle of a long shift.
        do_op(4'd4, 32'd1, 32'd20, w);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_zero", zero, 1'b1);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_op(4'd0, 32'd2, 32'd3, w); expect_result(32'd5, "post_rst_add", n, bz);
        chk("post_rst_lat", n, 1);

        // Random traffic with random backpressure; the compare process checks it all.
        rnd_rdy = 1;
        repeat (300) begin
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            case ($urandom_range(0, 5))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            do_op(rc, ra, rb, w);
            repeat ($urandom_range(0, 2)) step_inputs();
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            step_inputs();
            guard++;
        end
        if (q.size() > 0) timeout_fail("drain");
        repeat (2) step_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
